// File: rtl/gray_sync_rx.sv
// Receives a gray-coded count from a slower foreign clock domain, synchronises and decodes it,
// and reports each change with its modular step. Multi-bit gray steps are flagged and counted.
module gray_sync_rx #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [WIDTH-1:0]     i_gray_async,
  input  logic                 i_err_clr,
  output logic [WIDTH-1:0]     o_gray_sync,
  output logic [WIDTH-1:0]     o_bin,
  output logic                 o_valid,
  output logic [WIDTH-1:0]     o_delta,
  output logic                 o_init,
  output logic                 o_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  localparam logic [2:0]           SETTLE_N = 3'(SYNC_STAGES);
  localparam logic [WIDTH-1:0]     ONE_W    = WIDTH'(1);
  localparam logic [ERR_CNT_W-1:0] ONE_CNT  = ERR_CNT_W'(1);

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
    return (c == '1) ? c : c + ONE_CNT;
  endfunction

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0]     r_gprev;
  logic [WIDTH-1:0]     r_bin;
  logic [WIDTH-1:0]     r_delta;
  logic [2:0]           r_settle;
  logic                 r_init;
  logic                 r_valid;
  logic                 r_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic [WIDTH-1:0] w_gsync;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_bin_new;
  logic             w_settled;
  logic             w_change;
  logic             w_illegal;

  assign w_gsync   = r_sync[SYNC_STAGES-1];
  assign w_diff    = w_gsync ^ r_gprev;
  assign w_bin_new = gray2bin(w_gsync);
  assign w_settled = (r_settle == SETTLE_N);
  assign w_change  = r_init && (w_diff != '0);
  // Clearing the lowest set bit leaves something only when two or more bits flipped.
  assign w_illegal = w_change && ((w_diff & (w_diff - ONE_W)) != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= i_gray_async;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  // Wait for the chain to flush reset zeros before taking the baseline.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_settle <= '0;
      r_init   <= 1'b0;
    end else if (!r_init) begin
      if (w_settled) r_init <= 1'b1;
      else           r_settle <= r_settle + 3'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gprev <= '0;
      r_bin   <= '0;
      r_delta <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!r_init && w_settled) begin
        r_gprev <= w_gsync;
        r_bin   <= w_bin_new;
      end else if (w_change) begin
        r_valid <= 1'b1;
        r_gprev <= w_gsync;
        r_bin   <= w_bin_new;
        r_delta <= w_bin_new - r_bin;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (i_err_clr) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_illegal) begin
      r_err     <= 1'b1;
      r_err_cnt <= sat_inc(r_err_cnt);
    end
  end

  assign o_gray_sync = w_gsync;
  assign o_bin       = r_bin;
  assign o_valid     = r_valid;
  assign o_delta     = r_delta;
  assign o_init      = r_init;
  assign o_err       = r_err;
  assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_gray_sync_rx.sv
// Bench for gray_sync_rx: directed vector table, hand sequences for reset/saturation,
// and random stimulus checked against a sample-history reference model.
module tb_gray_sync_rx;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] gray_in;
  logic       clr;
  logic [3:0] o_gray_sync, o_bin, o_delta;
  logic       o_valid, o_init, o_err;
  logic [7:0] o_err_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  gray_sync_rx #(.WIDTH(4), .SYNC_STAGES(SS), .ERR_CNT_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_gray_async(gray_in), .i_err_clr(clr),
    .o_gray_sync(o_gray_sync), .o_bin(o_bin), .o_valid(o_valid), .o_delta(o_delta),
    .o_init(o_init), .o_err(o_err), .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, time=%0t required=finish", $time);
    $fatal(1, "watchdog");
  end

  // Reference model: the synchronised value is simply the input sampled SS edges ago.
  logic [3:0] hist[$];
  int         m_edges;
  logic       m_init, m_valid, m_err;
  logic [3:0] m_prev, m_bin, m_delta, m_gsync;
  logic [7:0] m_cnt;

  function automatic logic [3:0] dec(input logic [3:0] g);
    logic [3:0] b = '0;
    for (int s = 0; s < 4; s++) b ^= g >> s;
    return b;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_edges = 0; m_init = 0; m_valid = 0; m_err = 0;
    m_prev = 0; m_bin = 0; m_delta = 0; m_gsync = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    logic [3:0] g_now, nb;
    logic       bad;
    if (!rst_n) begin
      model_reset();
      return;
    end
    g_now = (hist.size() >= SS) ? hist[0] : 4'd0;
    hist.push_back(gray_in);
    if (hist.size() > SS) void'(hist.pop_front());
    m_gsync = (hist.size() >= SS) ? hist[0] : 4'd0;
    if (m_edges < 1000) m_edges++;
    m_valid = 0;
    bad = 0;
    if (!m_init) begin
      if (m_edges == SS + 1) begin
        m_init = 1; m_prev = g_now; m_bin = dec(g_now);
      end
    end else if (g_now != m_prev) begin
      nb = dec(g_now);
      m_valid = 1;
      m_delta = nb - m_bin;
      bad = ($countones(g_now ^ m_prev) >= 2);
      m_bin = nb; m_prev = g_now;
    end
    if (clr) begin
      m_err = 0; m_cnt = 0;
    end else if (bad) begin
      m_err = 1;
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("m_gray_sync", 32'(o_gray_sync), 32'(m_gsync));
    chk("m_bin",       32'(o_bin),       32'(m_bin));
    chk("m_valid",     32'(o_valid),     32'(m_valid));
    chk("m_delta",     32'(o_delta),     32'(m_delta));
    chk("m_init",      32'(o_init),      32'(m_init));
    chk("m_err",       32'(o_err),       32'(m_err));
    chk("m_err_cnt",   32'(o_err_cnt),   32'(m_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gsync"}, 32'(o_gray_sync), 0);
    chk({tag, "_bin"},   32'(o_bin),       0);
    chk({tag, "_valid"}, 32'(o_valid),     0);
    chk({tag, "_delta"}, 32'(o_delta),     0);
    chk({tag, "_init"},  32'(o_init),      0);
    chk({tag, "_err"},   32'(o_err),       0);
    chk({tag, "_cnt"},   32'(o_err_cnt),   0);
  endtask

  typedef struct {
    logic [3:0] gray;
    logic       clr;
    logic [3:0] bin;
    logic [3:0] delta;
    logic       err;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[14];

  task automatic run_rec(input vec_t v);
    gray_in = v.gray; clr = 1'b0;
    step();
    step();
    chk("v_early_valid", 32'(o_valid), 0);
    clr = v.clr;
    step();
    chk("v_valid", 32'(o_valid),   1);
    chk("v_bin",   32'(o_bin),     32'(v.bin));
    chk("v_delta", 32'(o_delta),   32'(v.delta));
    chk("v_err",   32'(o_err),     32'(v.err));
    chk("v_cnt",   32'(o_err_cnt), 32'(v.cnt));
    clr = 1'b0;
    step();
    chk("v_idle_valid", 32'(o_valid), 0);
  endtask

  task automatic rebaseline(input logic [3:0] exp_bin);
    step();
    chk("rb_init_e1", 32'(o_init), 0);
    step();
    chk("rb_init_e2", 32'(o_init), 0);
    step();
    chk("rb_init_e3",  32'(o_init),  1);
    chk("rb_bin_e3",   32'(o_bin),   32'(exp_bin));
    chk("rb_valid_e3", 32'(o_valid), 0);
    chk("rb_err_e3",   32'(o_err),   0);
  endtask

  initial begin
    //          gray    clr   bin    delta  err   cnt
    vecs[0]  = '{4'b0101, 1'b0, 4'd6,  4'd1,  1'b0, 8'd0};
    vecs[1]  = '{4'b0111, 1'b0, 4'd5,  4'd15, 1'b0, 8'd0};
    vecs[2]  = '{4'b0101, 1'b0, 4'd6,  4'd1,  1'b0, 8'd0};
    vecs[3]  = '{4'b0000, 1'b0, 4'd0,  4'd10, 1'b1, 8'd1};
    vecs[4]  = '{4'b0101, 1'b0, 4'd6,  4'd6,  1'b1, 8'd2};
    vecs[5]  = '{4'b0110, 1'b1, 4'd4,  4'd14, 1'b0, 8'd0};
    vecs[6]  = '{4'b0111, 1'b0, 4'd5,  4'd1,  1'b0, 8'd0};
    vecs[7]  = '{4'b0101, 1'b0, 4'd6,  4'd1,  1'b0, 8'd0};
    vecs[8]  = '{4'b0100, 1'b0, 4'd7,  4'd1,  1'b0, 8'd0};
    vecs[9]  = '{4'b1100, 1'b0, 4'd8,  4'd1,  1'b0, 8'd0};
    vecs[10] = '{4'b1101, 1'b0, 4'd9,  4'd1,  1'b0, 8'd0};
    vecs[11] = '{4'b1000, 1'b0, 4'd15, 4'd1,  1'b0, 8'd0};
    vecs[12] = '{4'b0000, 1'b0, 4'd0,  4'd1,  1'b0, 8'd0};
    vecs[13] = '{4'b0101, 1'b1, 4'd6,  4'd6,  1'b0, 8'd0};

    rst_n = 1'b0; gray_in = 4'b0111; clr = 1'b0;
    model_reset();
    #1;
    check_all_zero("por");
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("sync_latency", 32'(o_gray_sync), 32'(4'b0111));
    step();
    chk("init_e3",  32'(o_init),  1);
    chk("bin_e3",   32'(o_bin),   5);
    chk("valid_e3", 32'(o_valid), 0);
    chk("err_e3",   32'(o_err),   0);

    for (int i = 0; i <= 10; i++) run_rec(vecs[i]);

    chk("pre_rst_bin", 32'(o_bin), 9);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("midrst");
    gray_in = 4'b1001;
    step();
    step();
    rst_n = 1'b1;
    rebaseline(4'd14);

    for (int i = 11; i <= 12; i++) run_rec(vecs[i]);

    for (int k = 0; k < 300; k++) begin
      gray_in = (k % 2 == 0) ? 4'b0101 : 4'b0000;
      step(); step(); step();
    end
    chk("sat_err", 32'(o_err),     1);
    chk("sat_cnt", 32'(o_err_cnt), 255);

    run_rec(vecs[13]);

    begin
      logic [3:0] rb = 4'd6;
      int         rst_hold = 0;
      for (int n = 0; n < 2000; n++) begin
        int r = int'($urandom_range(0, 15));
        if (rst_hold > 0) begin
          rst_hold--;
          if (rst_hold == 0) rst_n = 1'b1;
        end else if (r == 13 && $urandom_range(0, 7) == 0) begin
          rst_n = 1'b0;
          model_reset();
          #1;
          check_model();
          rst_hold = 2;
        end
        if (r >= 6 && r <= 8)        rb = rb + 4'd1;
        else if (r == 9 || r == 10)  rb = rb - 4'd1;
        else if (r == 11 || r == 12) rb = 4'($urandom_range(0, 15));
        gray_in = rb ^ (rb >> 1);
        clr = ($urandom_range(0, 15) == 0);
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
